// File: rtl/parallel_to_serial_lanes_lane_select.sv
// rtl/parallel_to_serial_lanes_lane_select.sv - combinational pick of one lane of a word
// Beat index i maps to lane i (order = 0) or lane beats-1-i (order = 1).
module parallel_to_serial_lanes_lane_select #(
  parameter int width       = 8,
  parameter int lane_width  = 1,
  parameter int index_width = 3
) (
  input  logic [width-1:0]       word,
  input  logic                   order,
  input  logic [index_width-1:0] index,
  output logic [lane_width-1:0]  lane
);

  localparam int beats = width / lane_width;

  int lane_idx;

  // Constant-indexed mux avoids a variable part-select wider than the word.
  always_comb begin
    lane_idx = order ? (beats - 1 - int'(index)) : int'(index);
    lane     = '0;
    for (int k = 0; k < beats; k++) begin
      if (k == lane_idx) begin
        lane = word[k*lane_width +: lane_width];
      end
    end
  end

endmodule

// File: rtl/parallel_to_serial_lanes.sv
// rtl/parallel_to_serial_lanes.sv - word to lane-wide beat serialiser with ready/valid on both sides
// IDLE bypasses beat 0 combinationally; SHIFT walks the held word and chains the next word gaplessly.
module parallel_to_serial_lanes #(
  parameter int width      = 8,
  parameter int lane_width = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  parallel_valid,
  output logic                  parallel_ready,
  input  logic [width-1:0]      parallel_data,
  input  logic                  msb_first,
  output logic                  serial_valid,
  input  logic                  serial_ready,
  output logic [lane_width-1:0] serial_data,
  output logic                  serial_last,
  output logic                  busy
);

  localparam int beats       = (lane_width > 0) ? (width / lane_width) : 1;
  localparam int index_width = (beats > 1) ? $clog2(beats) : 1;
  localparam logic [index_width-1:0] last_index = index_width'(beats - 1);

  generate
    if (lane_width == 0 || (width % ((lane_width == 0) ? 1 : lane_width)) != 0) begin : g_bad_params
      $error("parallel_to_serial_lanes: width must be a non-zero multiple of lane_width");
    end
  endgenerate

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state, next_state;
  logic [index_width-1:0] index, next_index;
  logic [width-1:0]       word_q;
  logic                   order_q;
  logic                   load;
  logic [lane_width-1:0]  bypass_lane;
  logic [lane_width-1:0]  held_lane;

  parallel_to_serial_lanes_lane_select #(
    .width       (width),
    .lane_width  (lane_width),
    .index_width (index_width)
  ) u_bypass_select (
    .word  (parallel_data),
    .order (msb_first),
    .index ('0),
    .lane  (bypass_lane)
  );

  parallel_to_serial_lanes_lane_select #(
    .width       (width),
    .lane_width  (lane_width),
    .index_width (index_width)
  ) u_held_select (
    .word  (word_q),
    .order (order_q),
    .index (index),
    .lane  (held_lane)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      index   <= '0;
      word_q  <= '0;
      order_q <= 1'b0;
    end else begin
      state <= next_state;
      index <= next_index;
      if (load) begin
        word_q  <= parallel_data;
        order_q <= msb_first;
      end
    end
  end

  always_comb begin
    next_state     = state;
    next_index     = index;
    load           = 1'b0;
    parallel_ready = 1'b0;
    serial_valid   = 1'b0;
    serial_data    = '0;
    serial_last    = 1'b0;
    case (state)
      IDLE: begin
        parallel_ready = 1'b1;
        serial_valid   = parallel_valid;
        serial_data    = parallel_valid ? bypass_lane : '0;
        serial_last    = parallel_valid && (beats == 1);
        if (parallel_valid) begin
          load = 1'b1;
          if (!serial_ready) begin
            // Beat 0 was not taken; re-present it from the register.
            next_state = SHIFT;
            next_index = '0;
          end else if (beats > 1) begin
            next_state = SHIFT;
            next_index = index_width'(1);
          end
        end
      end
      SHIFT: begin
        serial_valid   = 1'b1;
        serial_data    = held_lane;
        serial_last    = (index == last_index);
        parallel_ready = serial_ready && serial_last;
        if (serial_ready) begin
          if (index != last_index) begin
            next_index = index + index_width'(1);
          end else if (parallel_valid) begin
            load       = 1'b1;
            next_index = '0;
          end else begin
            next_state = IDLE;
            next_index = '0;
          end
        end
      end
      default: begin
        next_state = IDLE;
        next_index = '0;
      end
    endcase
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_parallel_to_serial_lanes.sv
// tb/tb_parallel_to_serial_lanes.sv - scoreboard bench over 8/1, 16/4, 8/4 and 8/8 configurations
module tb_parallel_to_serial_lanes;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // a: 8/1, b: 16/4, c: 8/4, d: 8/8
  logic       pv_a, pr_a, mf_a, sv_a, sr_a, sd_a, sl_a, busy_a;
  logic [7:0] pd_a;
  logic       pv_b, pr_b, mf_b, sv_b, sr_b, sl_b, busy_b;
  logic [15:0] pd_b;
  logic [3:0] sd_b;
  logic       pv_c, pr_c, mf_c, sv_c, sr_c, sl_c, busy_c;
  logic [7:0] pd_c;
  logic [3:0] sd_c;
  logic       pv_d, pr_d, mf_d, sv_d, sr_d, sl_d, busy_d;
  logic [7:0] pd_d, sd_d;

  parallel_to_serial_lanes #(.width(8), .lane_width(1)) u_a (
    .clk(clk), .rst(rst), .parallel_valid(pv_a), .parallel_ready(pr_a), .parallel_data(pd_a),
    .msb_first(mf_a), .serial_valid(sv_a), .serial_ready(sr_a), .serial_data(sd_a),
    .serial_last(sl_a), .busy(busy_a));
  parallel_to_serial_lanes #(.width(16), .lane_width(4)) u_b (
    .clk(clk), .rst(rst), .parallel_valid(pv_b), .parallel_ready(pr_b), .parallel_data(pd_b),
    .msb_first(mf_b), .serial_valid(sv_b), .serial_ready(sr_b), .serial_data(sd_b),
    .serial_last(sl_b), .busy(busy_b));
  parallel_to_serial_lanes #(.width(8), .lane_width(4)) u_c (
    .clk(clk), .rst(rst), .parallel_valid(pv_c), .parallel_ready(pr_c), .parallel_data(pd_c),
    .msb_first(mf_c), .serial_valid(sv_c), .serial_ready(sr_c), .serial_data(sd_c),
    .serial_last(sl_c), .busy(busy_c));
  parallel_to_serial_lanes #(.width(8), .lane_width(8)) u_d (
    .clk(clk), .rst(rst), .parallel_valid(pv_d), .parallel_ready(pr_d), .parallel_data(pd_d),
    .msb_first(mf_d), .serial_valid(sv_d), .serial_ready(sr_d), .serial_data(sd_d),
    .serial_last(sl_d), .busy(busy_d));

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } beat_t;

  beat_t q_a[$], q_b[$], q_c[$], q_d[$];
  beat_t ea, eb, ec, ed;
  int checks = 0;
  int errors = 0;

  logic       prev_stall_b = 1'b0;
  logic [3:0] prev_data_b  = '0;
  logic       prev_last_b  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_beat(input logic [15:0] w, input int lw, input int nb,
                                             input bit m, input int i);
    int          lane;
    logic [15:0] mask;
    lane = m ? (nb - 1 - i) : i;
    mask = 16'((32'h1 << lw) - 1);
    return (w >> (lane * lw)) & mask;
  endfunction

  task automatic push_exp(input int inst, input logic [15:0] w, input bit m);
    int    lw, nb;
    beat_t e;
    case (inst)
      0:       begin lw = 1; nb = 8; end
      1:       begin lw = 4; nb = 4; end
      2:       begin lw = 4; nb = 2; end
      default: begin lw = 8; nb = 1; end
    endcase
    for (int i = 0; i < nb; i++) begin
      e.data = model_beat(w, lw, nb, m, i);
      e.last = (i == nb - 1);
      case (inst)
        0:       q_a.push_back(e);
        1:       q_b.push_back(e);
        2:       q_c.push_back(e);
        default: q_d.push_back(e);
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && sv_a && sr_a) begin
      if (q_a.size() == 0) check("a_extra_beat", 32'(sd_a), 32'hFFFF_FFFF);
      else begin
        ea = q_a.pop_front();
        check("a_data", 32'(sd_a), 32'(ea.data));
        check("a_last", 32'(sl_a), 32'(ea.last));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall_b) begin
        check("b_stall_valid", 32'(sv_b), 32'd1);
        check("b_stall_data", 32'(sd_b), 32'(prev_data_b));
        check("b_stall_last", 32'(sl_b), 32'(prev_last_b));
      end
      if (busy_b) check("b_pr", 32'(pr_b), 32'(sr_b & sl_b));
      if (sv_b && sr_b) begin
        if (q_b.size() == 0) check("b_extra_beat", 32'(sd_b), 32'hFFFF_FFFF);
        else begin
          eb = q_b.pop_front();
          check("b_data", 32'(sd_b), 32'(eb.data));
          check("b_last", 32'(sl_b), 32'(eb.last));
        end
      end
    end
    prev_stall_b <= !rst && sv_b && !sr_b;
    prev_data_b  <= sd_b;
    prev_last_b  <= sl_b;
  end

  always @(negedge clk) begin
    if (!rst && sv_c && sr_c) begin
      if (q_c.size() == 0) check("c_extra_beat", 32'(sd_c), 32'hFFFF_FFFF);
      else begin
        ec = q_c.pop_front();
        check("c_data", 32'(sd_c), 32'(ec.data));
        check("c_last", 32'(sl_c), 32'(ec.last));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && sv_d && sr_d) begin
      if (q_d.size() == 0) check("d_extra_beat", 32'(sd_d), 32'hFFFF_FFFF);
      else begin
        ed = q_d.pop_front();
        check("d_data", 32'(sd_d), 32'(ed.data));
        check("d_last", 32'(sl_d), 32'(ed.last));
      end
    end
  end

  // Offers one word to instance b and returns once it has fully drained.
  task automatic send_b(input logic [15:0] w, input bit m, input bit rnd);
    bit acc, left, done;
    done = 1'b0;
    pd_b = w;
    mf_b = m;
    pv_b = 1'b1;
    sr_b = rnd ? 1'b0 : 1'b1;
    push_exp(1, w, m);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      acc  = pv_b && pr_b;
      left = !pv_b && !busy_b;
      tick();
      if (acc) begin
        pv_b = 1'b0;
        pd_b = 16'($urandom);
        mf_b = ~m;
      end
      sr_b = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      done = left;
    end
    if (!done) check("b_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    pv_a = 0; pd_a = '0; mf_a = 0; sr_a = 1;
    pv_b = 0; pd_b = '0; mf_b = 0; sr_b = 1;
    pv_c = 0; pd_c = '0; mf_c = 0; sr_c = 1;
    pv_d = 0; pd_d = '0; mf_d = 0; sr_d = 1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_valid", 32'(sv_a), 32'd0);
    check("rst_a_ready", 32'(pr_a), 32'd1);
    check("rst_a_busy", 32'(busy_a), 32'd0);
    check("rst_a_last", 32'(sl_a), 32'd0);
    check("rst_a_data", 32'(sd_a), 32'd0);
    check("rst_b_data", 32'(sd_b), 32'd0);
    check("rst_c_ready", 32'(pr_c), 32'd1);
    check("rst_d_valid", 32'(sv_d), 32'd0);
    tick();
    rst = 1'b0;

    // 8/1, 0xA5 LSB first: beat 0 same cycle, busy on cycles 1..7
    tick();
    pd_a = 8'hA5; mf_a = 0; pv_a = 1;
    push_exp(0, 16'h00A5, 1'b0);
    @(negedge clk);
    check("a5_c0_valid", 32'(sv_a), 32'd1);
    check("a5_c0_busy", 32'(busy_a), 32'd0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) pv_a = 0;
      @(negedge clk);
      check($sformatf("a5_busy_c%0d", c), 32'(busy_a), 32'(c <= 7));
    end
    check("a5_drained", 32'(q_a.size()), 32'd0);

    // 16/4 directed, both orders, no backpressure
    tick();
    send_b(16'h1234, 1'b1, 1'b0);
    send_b(16'h1234, 1'b0, 1'b0);
    check("b_directed_drained", 32'(q_b.size()), 32'd0);

    // 16/4 random backpressure, stalled on the accept cycle
    for (int n = 0; n < 8; n++) send_b(16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    sr_b = 1'b1;
    check("b_random_drained", 32'(q_b.size()), 32'd0);

    // 8/4 back-to-back 0x3C then 0x81
    pd_c = 8'h3C; mf_c = 0; pv_c = 1; sr_c = 1;
    push_exp(2, 16'h003C, 1'b0);
    @(negedge clk);
    check("b2b_pr_c0", 32'(pr_c), 32'd1);
    tick();
    pd_c = 8'h81;
    push_exp(2, 16'h0081, 1'b0);
    @(negedge clk);
    check("b2b_pr_c1", 32'(pr_c), 32'd1);
    tick();
    pv_c = 0;
    @(negedge clk);
    check("b2b_pr_c2", 32'(pr_c), 32'd0);
    check("b2b_valid_c2", 32'(sv_c), 32'd1);
    tick();
    @(negedge clk);
    check("b2b_valid_c3", 32'(sv_c), 32'd1);
    tick();
    @(negedge clk);
    check("b2b_valid_c4", 32'(sv_c), 32'd0);
    check("b2b_drained", 32'(q_c.size()), 32'd0);

    // 8/8 single-beat words: pass-through, busy only when stalled
    for (int n = 0; n < 3; n++) begin
      tick();
      pd_d = 8'($urandom); mf_d = 1'($urandom_range(0, 1)); pv_d = 1; sr_d = 1;
      push_exp(3, {8'h00, pd_d}, mf_d);
      @(negedge clk);
      check("d_pass_valid", 32'(sv_d), 32'd1);
      check("d_pass_busy", 32'(busy_d), 32'd0);
    end
    tick();
    pd_d = 8'h5A; pv_d = 1; sr_d = 0;
    push_exp(3, 16'h005A, 1'b0);
    @(negedge clk);
    check("d_stall_busy0", 32'(busy_d), 32'd0);
    tick();
    pv_d = 0; pd_d = 8'h00;
    @(negedge clk);
    check("d_stall_busy1", 32'(busy_d), 32'd1);
    check("d_stall_data", 32'(sd_d), 32'h5A);
    check("d_stall_last", 32'(sl_d), 32'd1);
    tick();
    sr_d = 1;
    @(negedge clk);
    check("d_release_busy", 32'(busy_d), 32'd1);
    tick();
    @(negedge clk);
    check("d_idle_busy", 32'(busy_d), 32'd0);
    check("d_idle_valid", 32'(sv_d), 32'd0);
    check("d_drained", 32'(q_d.size()), 32'd0);

    // 8/1 reset during beat 3 of 0xFF, then 0x01
    tick();
    pd_a = 8'hFF; mf_a = 0; pv_a = 1; sr_a = 1;
    push_exp(0, 16'h00FF, 1'b0);
    tick();
    pv_a = 0;
    tick();
    tick();
    rst = 1'b1;
    q_a.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_valid", 32'(sv_a), 32'd0);
    check("rstmid_busy", 32'(busy_a), 32'd0);
    check("rstmid_ready", 32'(pr_a), 32'd1);
    check("rstmid_last", 32'(sl_a), 32'd0);
    tick();
    pd_a = 8'h01; pv_a = 1;
    push_exp(0, 16'h0001, 1'b0);
    tick();
    pv_a = 0;
    repeat (8) tick();
    @(negedge clk);
    check("rstmid_after_valid", 32'(sv_a), 32'd0);
    check("rstmid_drained", 32'(q_a.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
